// File: rtl/canvas_mem_arbiter.sv
// Arbitrates one single-port canvas RAM between VGA scan-out reads, a canvas-clear sequencer
// and a buffered paint-write FIFO. Reads always win; paint writes drain only in free cycles.
module canvas_mem_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int COLOR_W    = 12,
  parameter int NUM_WORDS  = 19200,
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_valid,
  output logic [COLOR_W-1:0] rd_data,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic               clr_req,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               clr_busy,
  output logic               clr_done,
  output logic [CNT_W-1:0]   fifo_count,
  output logic               overflow,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata
);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  state_t               state, state_next;
  logic [ADDR_W-1:0]    clr_addr;
  logic [COLOR_W-1:0]   clr_color_q;
  logic                 clr_done_q;
  logic                 rd_valid_q;
  logic                 wr_ready_q;
  logic                 overflow_q;

  logic [ADDR_W-1:0]    fifo_addr [FIFO_DEPTH];
  logic [COLOR_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_next;

  logic                 rd_grant, clr_grant, pop_grant;
  logic                 clr_last;
  logic                 push;

  // Fixed priority: reader, then clear sequencer, then FIFO drain; nothing while in reset.
  always_comb begin
    rd_grant  = 1'b0;
    clr_grant = 1'b0;
    pop_grant = 1'b0;
    if (!reset) begin
      if (rd_req) begin
        rd_grant = 1'b1;
      end else if (state == ST_CLEAR) begin
        clr_grant = 1'b1;
      end else if (count != '0) begin
        pop_grant = 1'b1;
      end
    end
  end

  assign clr_last = clr_grant && (clr_addr == LAST_ADDR);
  assign push     = wr_req && wr_ready_q;

  always_comb begin
    count_next = count;
    case ({push, pop_grant})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (clr_req)  state_next = ST_CLEAR;
      ST_CLEAR: if (clr_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rd_grant) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end else if (clr_grant) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = clr_color_q;
    end else if (pop_grant) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = fifo_addr[rd_ptr];
      mem_wdata = fifo_data[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      clr_addr    <= '0;
      clr_color_q <= '0;
      clr_done_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state      <= state_next;
      clr_done_q <= clr_last;
      rd_valid_q <= rd_grant;
      if (state == ST_IDLE && clr_req) begin
        clr_addr    <= '0;
        clr_color_q <= clr_color;
      end else if (clr_grant && !clr_last) begin
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  // wr_ready is registered from the next count, so a pop from full frees a slot one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_ready_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      count      <= count_next;
      wr_ready_q <= (count_next != FULL_CNT);
      if (push)      wr_ptr <= wr_ptr + 1'b1;
      if (pop_grant) rd_ptr <= rd_ptr + 1'b1;
      if (wr_req && !wr_ready_q) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_valid_q ? mem_rdata : '0;
  assign wr_ready   = wr_ready_q;
  assign clr_busy   = (state == ST_CLEAR);
  assign clr_done   = clr_done_q;
  assign fifo_count = count;
  assign overflow   = overflow_q;

endmodule
